// File: rtl/ex_dreq.sv
// ex_dreq: EX-stage data-SRAM request issuer with ALE check and orphan-response tracking.
module ex_dreq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_mem_type,
  input  logic        ex_mem_we,
  input  logic [31:0] ex_vaddr,
  input  logic [31:0] ex_st_data,
  input  logic        ex_pre_ex,
  input  logic        mem_ex,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        mem_allowin,
  output logic        ex_ready_go,
  output logic        ex_ale,
  output logic        orphan_resp,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok
);
  typedef enum logic [1:0] {IDLE, REQ, SENT} state_e;
  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        acc, is_word, is_half, flush, issue, fsm_go;
  logic [1:0]  size_n;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  assign acc     = ex_valid & (ex_mem_type != 3'b000);
  assign is_word = ex_mem_type[1:0] == 2'b11;
  assign is_half = ex_mem_type[1:0] == 2'b01;
  assign ex_ale  = acc & ((is_half & ex_vaddr[0]) | (is_word & (ex_vaddr[1:0] != 2'b00)));
  assign flush   = wb_ex | ertn_flush;
  assign issue   = acc & ~ex_ale & ~ex_pre_ex & ~mem_ex & ~flush;
  assign size_n  = is_word ? 2'd2 : is_half ? 2'd1 : 2'd0;
  assign wstrb_n = ~ex_mem_we ? 4'b0000 :
                   is_word ? 4'b1111 :
                   is_half ? (4'b0011 << {ex_vaddr[1], 1'b0}) :
                   (4'b0001 << ex_vaddr[1:0]);
  assign wdata_n = is_word ? ex_st_data :
                   is_half ? {2{ex_st_data[15:0]}} :
                   {4{ex_st_data[7:0]}};
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    wr_d        = wr_q;
    size_d      = size_q;
    wstrb_d     = wstrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    orphan_resp = 1'b0;
    fsm_go      = 1'b0;
    case (state_q)
      IDLE: if (issue) begin
        state_d = REQ;
        wr_d    = ex_mem_we;
        size_d  = size_n;
        wstrb_d = wstrb_n;
        addr_d  = ex_vaddr;
        wdata_d = wdata_n;
      end
      REQ: if (data_sram_addr_ok) begin
        if (kill_q | flush) begin
          state_d     = IDLE;
          orphan_resp = 1'b1;
        end else begin
          fsm_go  = 1'b1;
          state_d = mem_allowin ? IDLE : SENT;
        end
      end else if (flush) begin
        kill_d = 1'b1;
      end
      SENT: begin
        fsm_go = 1'b1;
        if (flush) begin
          state_d     = IDLE;
          orphan_resp = 1'b1;
        end else if (mem_allowin) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) kill_d = 1'b0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign ex_ready_go     = ~acc | ex_ale | ex_pre_ex | fsm_go;
  assign data_sram_req   = state_q == REQ;
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
endmodule

// File: tb/tb_ex_dreq.sv
// tb_ex_dreq: directed and randomized checks of ex_dreq against a transaction-level reference model.
module tb_ex_dreq;
  logic        clk = 1'b0;
  logic        resetn, ex_valid, ex_mem_we, ex_pre_ex, mem_ex, wb_ex, ertn_flush, mem_allowin, addr_ok;
  logic [2:0]  ex_mem_type;
  logic [31:0] ex_vaddr, ex_st_data;
  logic        ex_ready_go, ex_ale, orphan_resp, data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  int n_tests = 0, n_fail = 0;
  bit          m_pend, m_sent, m_kill;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  always #5 clk = ~clk;
  ex_dreq dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_mem_type(ex_mem_type),
    .ex_mem_we(ex_mem_we), .ex_vaddr(ex_vaddr), .ex_st_data(ex_st_data),
    .ex_pre_ex(ex_pre_ex), .mem_ex(mem_ex), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .mem_allowin(mem_allowin), .ex_ready_go(ex_ready_go), .ex_ale(ex_ale),
    .orphan_resp(orphan_resp), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(addr_ok)
  );
  function automatic int nbytes(input logic [2:0] t);
    return (t[1:0] == 2'b11) ? 4 : (t[1:0] == 2'b01) ? 2 : 1;
  endfunction
  function automatic bit e_acc();
    return ex_valid && ex_mem_type != 3'b000;
  endfunction
  function automatic bit e_ale();
    return e_acc() && (ex_vaddr % nbytes(ex_mem_type) != 0);
  endfunction
  function automatic bit e_flush();
    return wb_ex || ertn_flush;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic model_clear();
    m_pend = 0; m_sent = 0; m_kill = 0;
    m_wr = 0; m_size = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
  endtask
  task automatic settle();
    bit orph, rg;
    @(negedge clk);
    orph = (m_pend && addr_ok && (m_kill || e_flush())) || (m_sent && e_flush());
    rg = !e_acc() || e_ale() || ex_pre_ex || (m_pend && addr_ok && !m_kill && !e_flush()) || m_sent;
    chk("req", data_sram_req, m_pend);
    chk("ready_go", ex_ready_go, rg);
    chk("ale", ex_ale, e_ale());
    chk("orphan", orphan_resp, orph);
    chk("wr", data_sram_wr, m_wr);
    chk("size", data_sram_size, m_size);
    chk("wstrb", data_sram_wstrb, m_wstrb);
    chk("addr", data_sram_addr, m_addr);
    chk("wdata", data_sram_wdata, m_wdata);
  endtask
  task automatic tick();
    int nb, off;
    @(posedge clk);
    nb = nbytes(ex_mem_type);
    off = int'(ex_vaddr[1:0]);
    if (!resetn) model_clear();
    else if (m_pend) begin
      if (addr_ok) begin
        m_sent = !(m_kill || e_flush()) && !mem_allowin;
        m_pend = 0;
        m_kill = 0;
      end else if (e_flush()) m_kill = 1;
    end else if (m_sent) begin
      if (e_flush() || mem_allowin) m_sent = 0;
    end else if (e_acc() && !e_ale() && !ex_pre_ex && !mem_ex && !e_flush()) begin
      m_pend  = 1;
      m_wr    = ex_mem_we;
      m_size  = 2'(nb / 2);
      m_wstrb = ex_mem_we ? 4'(((1 << nb) - 1) << (off - off % nb)) : 4'd0;
      m_addr  = ex_vaddr;
      for (int i = 0; i < 4; i++) m_wdata[8*i +: 8] = ex_st_data[8*(i % nb) +: 8];
    end
    #1;
  endtask
  task automatic cyc();
    settle();
    tick();
  endtask
  task automatic quiet();
    ex_valid = 0; ex_mem_type = 0; ex_mem_we = 0; ex_vaddr = 0; ex_st_data = 0;
    ex_pre_ex = 0; mem_ex = 0; wb_ex = 0; ertn_flush = 0; mem_allowin = 1; addr_ok = 0;
  endtask
  task automatic put(input logic [2:0] t, input logic we, input logic [31:0] va, input logic [31:0] sd);
    ex_valid = 1; ex_mem_type = t; ex_mem_we = we; ex_vaddr = va; ex_st_data = sd;
  endtask
  initial begin
    logic [2:0] types [6] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b101, 3'b110};
    resetn = 0;
    quiet();
    model_clear();
    cyc();
    #2 resetn = 1;
    cyc();
    put(3'b011, 0, 32'h1C000100, 0);
    settle(); chk("ldw_issue_rg", ex_ready_go, 0); chk("ldw_issue_req", data_sram_req, 0); tick();
    settle(); chk("ldw_req1", data_sram_req, 1); chk("ldw_rg1", ex_ready_go, 0); tick();
    cyc();
    addr_ok = 1;
    settle(); chk("ldw_ack_rg", ex_ready_go, 1); chk("ldw_addr", data_sram_addr, 32'h1C000100);
    chk("ldw_size", data_sram_size, 2); chk("ldw_wstrb", data_sram_wstrb, 0); tick();
    quiet();
    settle(); chk("ldw_idle_req", data_sram_req, 0); tick();
    put(3'b010, 1, 32'h00000403, 32'h123456AB); addr_ok = 1;
    cyc();
    settle(); chk("stb_wr", data_sram_wr, 1); chk("stb_size", data_sram_size, 0);
    chk("stb_wstrb", data_sram_wstrb, 4'b1000); chk("stb_wdata", data_sram_wdata, 32'hABABABAB);
    chk("stb_ale", ex_ale, 0); chk("stb_rg", ex_ready_go, 1); tick();
    quiet();
    cyc();
    put(3'b001, 0, 32'h00000101, 0);
    settle(); chk("ldh_ale", ex_ale, 1); chk("ldh_rg", ex_ready_go, 1); tick();
    settle(); chk("ldh_noreq", data_sram_req, 0); tick();
    ex_vaddr = 32'h00000100; ex_pre_ex = 1;
    settle(); chk("pre_ale", ex_ale, 0); chk("pre_rg", ex_ready_go, 1); tick();
    settle(); chk("pre_noreq", data_sram_req, 0); tick();
    quiet();
    put(3'b011, 0, 32'h00002000, 0);
    cyc();
    wb_ex = 1;
    settle(); chk("wb_req", data_sram_req, 1); chk("wb_rg", ex_ready_go, 0); tick();
    wb_ex = 0;
    settle(); chk("wb_addr_hold", data_sram_addr, 32'h2000); chk("wb_rg_hold", ex_ready_go, 0); tick();
    cyc();
    addr_ok = 1;
    settle(); chk("wb_orphan", orphan_resp, 1); chk("wb_ack_rg", ex_ready_go, 0); tick();
    quiet();
    settle(); chk("wb_idle_req", data_sram_req, 0); chk("wb_no_orphan", orphan_resp, 0); tick();
    put(3'b011, 0, 32'h00003000, 0); mem_allowin = 0;
    cyc();
    addr_ok = 1;
    settle(); chk("sent_ack_rg", ex_ready_go, 1); tick();
    addr_ok = 0;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("sent_rg", ex_ready_go, 1); chk("sent_req", data_sram_req, 0); tick();
    end
    mem_allowin = 1;
    cyc();
    quiet();
    cyc();
    put(3'b011, 0, 32'h00003004, 0); mem_allowin = 0;
    cyc();
    addr_ok = 1;
    cyc();
    addr_ok = 0; ertn_flush = 1;
    settle(); chk("ertn_orphan", orphan_resp, 1); tick();
    quiet();
    settle(); chk("ertn_idle_orphan", orphan_resp, 0); tick();
    put(3'b011, 1, 32'h00004000, 32'hDEADBEEF);
    cyc();
    #2 resetn = 0;
    model_clear();
    #1;
    chk("rst_req", data_sram_req, 0); chk("rst_wr", data_sram_wr, 0); chk("rst_size", data_sram_size, 0);
    chk("rst_wstrb", data_sram_wstrb, 0); chk("rst_addr", data_sram_addr, 0);
    chk("rst_wdata", data_sram_wdata, 0); chk("rst_orphan", orphan_resp, 0);
    cyc();
    quiet();
    #2 resetn = 1;
    settle(); chk("rst_after_orphan", orphan_resp, 0); chk("rst_after_req", data_sram_req, 0); tick();
    for (int i = 0; i < 400; i++) begin
      ex_valid    = ($urandom % 4) != 0;
      ex_mem_type = types[$urandom_range(0, 5)];
      ex_mem_we   = $urandom % 2;
      ex_vaddr    = $urandom;
      ex_st_data  = $urandom;
      ex_pre_ex   = ($urandom % 10) == 0;
      mem_ex      = ($urandom % 8) == 0;
      wb_ex       = ($urandom % 12) == 0;
      ertn_flush  = ($urandom % 20) == 0;
      mem_allowin = ($urandom % 4) != 0;
      addr_ok     = ($urandom % 3) == 0;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_dreq.md
Name: ex_dreq

Overview:
- Data-SRAM request issuer in the EX stage, directly upstream of the MEM stage.
- Decodes the load/store attributes of the valid EX instruction and performs the ALE alignment check.
- Drives the SRAM-like request channel (req/addr_ok handshake) and gates EX's ready_go until the address phase is accepted.
- Reports requests whose instruction was flushed after issue, so MEM can drop the matching data_ok.

Parameters:
- none (address and data are fixed at 32 bits)

Ports:
- clk  in  1  clock
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- ex_valid  in  1  EX holds a valid instruction
- ex_mem_type  in  3  000 = no access; [1:0]: 11 word, 01 half, 10 byte; [2] = unsigned load
- ex_mem_we  in  1  1 = store, 0 = load
- ex_vaddr  in  32  computed address (alu result)
- ex_st_data  in  32  store source register value
- ex_pre_ex  in  1  instruction already carries an exception from IF/ID
- mem_ex  in  1  MEM holds an excepting instruction; blocks new issue
- wb_ex  in  1  exception flush
- ertn_flush  in  1  ertn flush
- mem_allowin  in  1  MEM can accept
- ex_ready_go  out  1  EX may hand over to MEM
- ex_ale  out  1  address-misaligned exception for this instruction
- orphan_resp  out  1  one-cycle pulse: an accepted request belongs to a flushed instruction
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  write
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_wstrb  out  4  byte enables, 0000 for loads
- data_sram_addr  out  32  full byte address
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  address phase accepted

Behaviour:
- Derived signals:
  - acc = ex_valid & (ex_mem_type != 0).
  - ex_ale = acc & ((half & vaddr[0]) | (word & vaddr[1:0] != 0)).
  - flush = wb_ex | ertn_flush.
  - issue = acc & ~ex_ale & ~ex_pre_ex & ~mem_ex & ~flush.
- Request encoding (latched into output registers on issue):
  - size: byte 0, half 1, word 2.
  - wstrb: byte = 0001 << vaddr[1:0]; half = 0011 << {vaddr[1],0}; word = 1111; load = 0000.
  - wdata: byte = {4{st[7:0]}}; half = {2{st[15:0]}}; word = st.
  - addr = vaddr; wr = ex_mem_we.
- FSM states: IDLE, REQ, SENT. Sticky kill flag.
- IDLE:
  - data_sram_req = 0.
  - If issue: latch the request fields, go to REQ. No request goes out in the issue cycle (one cycle latency).
- REQ:
  - data_sram_req = 1. All request fields stay stable until addr_ok; a flush never withdraws a request.
  - On addr_ok with kill | flush: go to IDLE, pulse orphan_resp.
  - On addr_ok otherwise: ready_go = 1 this cycle. If mem_allowin, go to IDLE; else go to SENT.
- SENT:
  - req = 0, ready_go = 1.
  - mem_allowin: go to IDLE.
  - flush (priority over mem_allowin): go to IDLE, pulse orphan_resp.
- kill: set by flush while the state is not IDLE; cleared on entering IDLE.
- ex_ready_go:
  - 1 when ~acc, ex_ale, or ex_pre_ex.
  - Otherwise 1 only in REQ & addr_ok & ~kill & ~flush, or in SENT.
  - Always 0 in IDLE while issue is pending.
- mem_ex blocks issue only; it does not kill an in-flight request (the later wb_ex does).
- Reset (asynchronous): state = IDLE, kill = 0, req = 0, wr = 0, size = 0, wstrb = 0, addr = 0, wdata = 0, orphan_resp = 0. A reset during REQ drops req immediately, without waiting for a clock edge.
- Invariant: at most one outstanding address phase; no new issue until IDLE is re-entered.

Test Plan:
- ld.w at vaddr 0x1C000100, addr_ok asserted 2 cycles after req, mem_allowin = 1:
  - req high for 3 cycles; addr = 0x1C000100, size = 2, wstrb = 0, wr = 0.
  - ready_go = 1 only in the addr_ok cycle; state returns to IDLE.
- st.b at vaddr 0x00000403, st_data = 0x123456AB, addr_ok immediate:
  - wr = 1, size = 0, wstrb = 1000, wdata = 0xABABABAB; ale = 0.
- ld.h at vaddr 0x00000101:
  - ex_ale = 1, ready_go = 1, req never asserted, state stays IDLE.
  - Repeat with ex_pre_ex = 1 and an aligned address: same response.
- wb_ex pulse while in REQ, addr_ok 3 cycles later:
  - req held with fields unchanged; orphan_resp = 1 in the addr_ok cycle; ready_go stays 0; back to IDLE.
- addr_ok with mem_allowin = 0 for 2 cycles:
  - state goes to SENT, ready_go stays 1 throughout, req = 0.
  - Move to IDLE when mem_allowin rises. A later ertn_flush in SENT gives orphan_resp = 1.
- resetn driven low mid-REQ, asynchronous to clk:
  - data_sram_req and all outputs go to 0 immediately.
  - After release, state is IDLE and there is no spurious orphan_resp.
